// File: rtl/pipelined_adder_if.sv
// Operand/result bundle for pipelined_adder. The optional sub signal exists only
// when PIPELINED_ADDER_SUB_EN is defined.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both
// high. The producer holds its payload stable while valid is high and ready is low.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
`ifdef PIPELINED_ADDER_SUB_EN
    logic             sub;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
`else
    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );
    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder: WIDTH/SLICE stages, each stage adds one SLICE-wide slice.
// Define PIPELINED_ADDER_SUB_EN to add the bus.sub input (a - b when high).
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic             clk,
    input logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int STAGES = WIDTH / SLICE;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("pipelined_adder: WIDTH must be a multiple of SLICE");
    end

    logic             advance;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_c;

    // Per-stage registers. Each stage carries the full operands and the partial sum.
    // Slices are consumed in order, so the operands skew and the finished sum
    // slices deskew without any separate delay chains.
    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] s_q     [STAGES];
    logic [WIDTH-1:0] s_d     [STAGES];
    logic             ovf_q;
    logic             ovf_d;

    // Subtraction is folded in at entry as a + ~b + 1, so later stages only ever add.
    always_comb begin
        op_a = bus.a;
        op_b = bus.b;
        op_c = bus.c_in;
`ifdef PIPELINED_ADDER_SUB_EN
        if (bus.sub) begin
            op_b = ~bus.b;
            op_c = 1'b1;
        end
`endif
    end

    always_comb begin
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic             src_c;
        logic [SLICE-1:0] part;
        ovf_d = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_a = op_a;
                src_b = op_b;
                src_s = '0;
                src_c = op_c;
            end else begin
                src_a = a_q[k-1];
                src_b = b_q[k-1];
                src_s = s_q[k-1];
                src_c = carry_q[k-1];
            end
            {carry_d[k], part} = {1'b0, src_a[k*SLICE +: SLICE]}
                               + {1'b0, src_b[k*SLICE +: SLICE]}
                               + {{SLICE{1'b0}}, src_c};
            s_d[k] = src_s;
            s_d[k][k*SLICE +: SLICE] = part;
            a_d[k] = src_a;
            b_d[k] = src_b;
            // The carry into the MSB is recovered as a ^ b ^ sum at the MSB.
            if (k == LAST) begin
                ovf_d = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ part[SLICE-1] ^ carry_d[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                s_q[k]     <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            valid_q[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                carry_q[k] <= carry_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                s_q[k]     <= s_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    // The whole pipeline moves as one unit. It stalls only while the output
    // register holds a result that the consumer has not yet taken.
    assign advance       = !valid_q[LAST] || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[LAST];
    assign bus.sum       = s_q[LAST];
    assign bus.c_out     = carry_q[LAST];
    assign bus.ovf       = ovf_q;
endmodule
